if_fetch_ctrl: RTL

//   Fetch-side requester for the synchronous instruction memory (imem) in the IF stage.

---
 rtl/if_fetch_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch requester: drives imem_pc, aligns the 1-cycle imem read data with its PC,
// holds the presented word across stalls and drops wrong-path words on redirect.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [31:0] resp_pc_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic        hold_load;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic [31:0] reset_pc_al;

  // Low address bits are masked rather than sliced away so the full vectors stay in use.
  assign target      = redirect_pc & ~32'h3;
  assign reset_pc_al = RESET_PC & ~32'h3;
  assign pc_inc      = pc_q + 32'd4;
  assign imem_pc     = pc_q;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    hold_load = 1'b0;
    if_valid  = 1'b0;
    if_pc     = 32'h0;
    if_instr  = NOP_INSTR;
    case (state)
      BUBBLE: begin
        if (redirect_en) begin
          pc_nxt = target;
        end else begin
          pc_nxt    = pc_inc;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if_valid = 1'b1;
        if_pc    = resp_pc_q;
        if_instr = imem_instr;
        if (redirect_en) begin
          pc_nxt    = target;
          state_nxt = BUBBLE;
        end else if (stall) begin
          hold_load = 1'b1;
          state_nxt = HOLD;
        end else begin
          pc_nxt = pc_inc;
        end
      end
      HOLD: begin
        if_valid = 1'b1;
        if_pc    = hold_pc_q;
        if_instr = hold_instr_q;
        if (redirect_en) begin
          pc_nxt    = target;
          state_nxt = BUBBLE;
        end else if (!stall) begin
          pc_nxt    = pc_inc;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BUBBLE;
      end
    endcase
    // Nothing is presented while reset is asserted, whatever the state register holds.
    if (rst) begin
      if_valid = 1'b0;
      if_pc    = 32'h0;
      if_instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BUBBLE;
      pc_q         <= reset_pc_al;
      resp_pc_q    <= reset_pc_al;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      resp_pc_q <= pc_q;
      if (hold_load) begin
        hold_pc_q    <= resp_pc_q;
        hold_instr_q <= imem_instr;
      end
    end
  end

endmodule
